// File: rtl/tse_rx_parser_if.sv
// -----------------------------------------------------------------------------
// tse_rx_parser_if
// Avalon-ST receive bus between the TSE MAC RX FIFO (master) and
// tse_rx_parser (slave).
//
// Signals:
//   SINK_DATA  [31:0] beat data, first byte on [31:24]
//   SINK_VALID        beat valid
//   SINK_SOP          start of packet
//   SINK_EOP          end of packet
//   SINK_EMPTY [1:0]  empty bytes on the EOP beat
//   SINK_ERROR [5:0]  MAC error flags, meaningful on the EOP beat
//   SINK_READY        sink ready (driven by the slave)
// -----------------------------------------------------------------------------
interface tse_rx_parser_if;
  logic [31:0] SINK_DATA;
  logic        SINK_VALID;
  logic        SINK_SOP;
  logic        SINK_EOP;
  logic [1:0]  SINK_EMPTY;
  logic [5:0]  SINK_ERROR;
  logic        SINK_READY;

  modport master (
    output SINK_DATA, SINK_VALID, SINK_SOP, SINK_EOP, SINK_EMPTY, SINK_ERROR,
    input  SINK_READY
  );

  modport slave (
    input  SINK_DATA, SINK_VALID, SINK_SOP, SINK_EOP, SINK_EMPTY, SINK_ERROR,
    output SINK_READY
  );
endinterface

// File: rtl/tse_rx_parser.sv
// -----------------------------------------------------------------------------
// tse_rx_parser
// Receive-side counterpart of tse_controller. Consumes Ethernet frames from
// the TSE MAC RX Avalon-ST port, accepts only frames with the configured
// EtherType, and publishes the speed, ADC and sequence fields of every good
// frame. Good and dropped frames are counted.
//
// Frame words (index from SOP = 0):
//   w0 dst[47:16]  w1 dst[15:0]|src[47:32]  w2 src[31:0]
//   w3 EtherType[31:16]|speed[15:0]  w4 ADC[31:16]|seq[15:0]  w5.. payload
//
// Ports:
//   CLOCK             sole clock
//   RESET_N           asynchronous active-low reset
//   sink              Avalon-ST sink (tse_rx_parser_if.slave)
//   SPEED_SENSOR_OUT  speed field of the last good frame
//   ADC_OUT           ADC field of the last good frame
//   SEQ_OUT           sequence number of the last good frame
//   FIELDS_VALID      one-cycle strobe when new fields are published
//   RX_GOOD_COUNT     accepted frames (wraps)
//   RX_DROP_COUNT     dropped frames (wraps)
//   SEQ_ERROR         sequence-gap strobe, aligned with FIELDS_VALID
//
// Optional feature: define TSE_RX_SEQ_CHECK_EN to enable sequence-gap
// detection; otherwise SEQ_ERROR is tied low.
// -----------------------------------------------------------------------------
module tse_rx_parser #(
  parameter int          SPEED_SENSOR_WIDTH   = 16,
  parameter int          ADC_WIDTH            = 16,
  parameter int          TSE_RX_ST_DATA_WIDTH = 32,
  parameter logic [15:0] ETHERTYPE            = 16'h88B5,
  parameter int          COUNT_WIDTH          = 16
) (
  input  logic                          CLOCK,
  input  logic                          RESET_N,
  tse_rx_parser_if.slave                sink,
  output logic [SPEED_SENSOR_WIDTH-1:0] SPEED_SENSOR_OUT,
  output logic [ADC_WIDTH-1:0]          ADC_OUT,
  output logic [15:0]                   SEQ_OUT,
  output logic                          FIELDS_VALID,
  output logic [COUNT_WIDTH-1:0]        RX_GOOD_COUNT,
  output logic [COUNT_WIDTH-1:0]        RX_DROP_COUNT,
  output logic                          SEQ_ERROR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_TYPE,
    S_DATA,
    S_DRAIN,
    S_DISCARD
  } state_t;

  state_t state_reg, state_next;

  // Next header word expected while in S_HDR (1 or 2).
  logic [1:0] hdr_idx_reg, hdr_idx_next;

  // Fields are staged here and only become visible when the frame ends cleanly.
  logic [SPEED_SENSOR_WIDTH-1:0] speed_shadow_reg, speed_shadow_next;
  logic [ADC_WIDTH-1:0]          adc_shadow_reg, adc_shadow_next;
  logic [15:0]                   seq_shadow_reg, seq_shadow_next;

  logic                          ready_reg;
  logic [SPEED_SENSOR_WIDTH-1:0] speed_out_reg;
  logic [ADC_WIDTH-1:0]          adc_out_reg;
  logic [15:0]                   seq_out_reg;
  logic                          fields_valid_reg;
  logic [COUNT_WIDTH-1:0]        good_count_reg;
  logic [COUNT_WIDTH-1:0]        drop_count_reg;

  logic       beat;
  logic       err_ok;
  logic       publish;
  // A preempting SOP that is itself a single-beat runt drops two frames at once.
  logic [1:0] drop_inc;

  // Inputs with no bearing on parsing; kept visible so they are not flagged.
  logic unused_bits;
  assign unused_bits = ^{sink.SINK_EMPTY, (TSE_RX_ST_DATA_WIDTH == 32)};

  assign beat   = sink.SINK_VALID & ready_reg;
  assign err_ok = (sink.SINK_ERROR == 6'd0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg        <= S_IDLE;
      hdr_idx_reg      <= 2'd0;
      speed_shadow_reg <= '0;
      adc_shadow_reg   <= '0;
      seq_shadow_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      hdr_idx_reg      <= hdr_idx_next;
      speed_shadow_reg <= speed_shadow_next;
      adc_shadow_reg   <= adc_shadow_next;
      seq_shadow_reg   <= seq_shadow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and frame-outcome decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    hdr_idx_next      = hdr_idx_reg;
    speed_shadow_next = speed_shadow_reg;
    adc_shadow_next   = adc_shadow_reg;
    seq_shadow_next   = seq_shadow_reg;
    publish           = 1'b0;
    drop_inc          = 2'd0;

    if (beat) begin
      if (sink.SINK_SOP) begin
        // A new frame always restarts parsing at w0; anything in flight is lost.
        if (state_reg != S_IDLE) begin
          drop_inc = drop_inc + 2'd1;
        end
        if (sink.SINK_EOP) begin
          drop_inc   = drop_inc + 2'd1;
          state_next = S_IDLE;
        end else begin
          state_next   = S_HDR;
          hdr_idx_next = 2'd1;
        end
      end else begin
        case (state_reg)
          S_IDLE: begin
            // Stray mid-frame beats with no SOP seen are ignored.
          end

          S_HDR: begin
            if (sink.SINK_EOP) begin
              drop_inc   = 2'd1;
              state_next = S_IDLE;
            end else if (hdr_idx_reg == 2'd2) begin
              state_next = S_TYPE;
            end else begin
              hdr_idx_next = hdr_idx_reg + 2'd1;
            end
          end

          S_TYPE: begin
            speed_shadow_next = sink.SINK_DATA[SPEED_SENSOR_WIDTH-1:0];
            if (sink.SINK_EOP) begin
              drop_inc   = 2'd1;
              state_next = S_IDLE;
            end else if (sink.SINK_DATA[31:16] != ETHERTYPE) begin
              state_next = S_DISCARD;
            end else begin
              state_next = S_DATA;
            end
          end

          S_DATA: begin
            adc_shadow_next = sink.SINK_DATA[16 +: ADC_WIDTH];
            seq_shadow_next = sink.SINK_DATA[15:0];
            if (sink.SINK_EOP) begin
              // Five-word frame: w4 is also the last beat.
              publish    = err_ok;
              drop_inc   = {1'b0, ~err_ok};
              state_next = S_IDLE;
            end else begin
              state_next = S_DRAIN;
            end
          end

          S_DRAIN: begin
            if (sink.SINK_EOP) begin
              publish    = err_ok;
              drop_inc   = {1'b0, ~err_ok};
              state_next = S_IDLE;
            end
          end

          S_DISCARD: begin
            if (sink.SINK_EOP) begin
              drop_inc   = 2'd1;
              state_next = S_IDLE;
            end
          end

          default: begin
            state_next = S_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Published fields and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ready_reg        <= 1'b0;
      speed_out_reg    <= '0;
      adc_out_reg      <= '0;
      seq_out_reg      <= '0;
      fields_valid_reg <= 1'b0;
      good_count_reg   <= '0;
      drop_count_reg   <= '0;
    end else begin
      ready_reg        <= 1'b1;
      fields_valid_reg <= publish;
      if (publish) begin
        // _next already holds the live w4 data when EOP lands on w4.
        speed_out_reg  <= speed_shadow_reg;
        adc_out_reg    <= adc_shadow_next;
        seq_out_reg    <= seq_shadow_next;
        good_count_reg <= good_count_reg + 1'b1;
      end
      drop_count_reg <= drop_count_reg + COUNT_WIDTH'(drop_inc);
    end
  end

`ifdef TSE_RX_SEQ_CHECK_EN
  // The first good frame after reset only seeds the expected sequence.
  logic        have_prev_reg;
  logic [15:0] prev_seq_reg;
  logic        seq_error_reg;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      have_prev_reg <= 1'b0;
      prev_seq_reg  <= 16'd0;
      seq_error_reg <= 1'b0;
    end else begin
      seq_error_reg <= 1'b0;
      if (publish) begin
        have_prev_reg <= 1'b1;
        prev_seq_reg  <= seq_shadow_next;
        seq_error_reg <= have_prev_reg && (seq_shadow_next != prev_seq_reg + 16'd1);
      end
    end
  end

  assign SEQ_ERROR = seq_error_reg;
`else
  assign SEQ_ERROR = 1'b0;
`endif

  assign sink.SINK_READY  = ready_reg;
  assign SPEED_SENSOR_OUT = speed_out_reg;
  assign ADC_OUT          = adc_out_reg;
  assign SEQ_OUT          = seq_out_reg;
  assign FIELDS_VALID     = fields_valid_reg;
  assign RX_GOOD_COUNT    = good_count_reg;
  assign RX_DROP_COUNT    = drop_count_reg;

endmodule
